jtframe_dwnld_wrsched: RTL and testbench

Write scheduler between the MiST SPI download path (ioctl byte stream) and the SDRAM controller's programming port. It buffers incoming ROM bytes in a small FIFO and issues byte-masked SDRAM write requests with a req/ack handshake. It generates dwnld_busy, which holds the game core in reset until every byte has landed in SDRAM plus a settle period. It sits in the MiST top between the ioctl decoder and the SDRAM controller.

---
 rtl/jtframe_dwnld_pkg.sv | 27 ++
 rtl/jtframe_dwnld_fifo.sv | 84 ++++++++
 rtl/jtframe_dwnld_wrsched.sv | 175 +++++++++++++++++
 tb/tb_jtframe_dwnld_wrsched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_dwnld_pkg.sv
// Shared definitions for the ROM download write scheduler.
// Holds the FSM state encoding, the SDRAM byte-mask constants and a helper
// that converts the byte lane of an ioctl address into an SDRAM byte mask.
package jtframe_dwnld_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wr_state_t;

    // Byte masks are active-low: a 0 bit enables that lane.
    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_HI   = 2'b01;
    localparam logic [1:0] MASK_NONE = 2'b11;

    // Lane 0 is the low byte of the 16-bit SDRAM word, lane 1 the high byte.
    function automatic logic [1:0] lane_mask(input logic lane);
        logic [1:0] mask;
        if (lane) begin
            mask = MASK_HI;
        end else begin
            mask = MASK_LO;
        end
        return mask;
    endfunction

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// Small synchronous first-word-fall-through FIFO for download bytes.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   push, din - write request and data; ignored when full unless pop is
//               also accepted in the same cycle
//   pop       - read request; ignored when empty
//   dout      - head entry, valid whenever empty is low
//   empty     - no entries stored
//   full      - DEPTH entries stored
module jtframe_dwnld_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic          wr_en_s;
    logic          rd_en_s;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_MAX);
    assign dout  = mem_q[rd_ptr_q];

    // Accept/pointer/count next-state; a pop frees the slot a full push needs.
    always_comb begin
        rd_en_s  = pop && !empty;
        wr_en_s  = push && (!full || rd_en_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        if (wr_en_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/jtframe_dwnld_wrsched.sv
// Write scheduler between the ioctl download byte stream and the SDRAM
// programming port. Bytes are queued in a small FIFO and written one at a
// time with a prog_we/prog_rdy handshake; dwnld_busy keeps the core in reset
// until the download ends, all bytes are written and a settle period passes.
// Ports:
//   clk, rst                          - SDRAM clock, synchronous reset
//   downloading                       - ROM transfer in progress
//   ioctl_wr, ioctl_addr, ioctl_dout  - incoming byte strobe/address/data
//   prog_we, prog_addr, prog_data,
//   prog_mask                         - SDRAM write request (held until ack)
//   prog_rdy                          - SDRAM write acknowledge
//   dwnld_busy                        - download or write-back pending
//   overflow                          - sticky: a byte was dropped
module jtframe_dwnld_wrsched
    import jtframe_dwnld_pkg::*;
#(
    parameter int AW         = 22,
    parameter int FIFO_DEPTH = 4,
    parameter int HOLD       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          downloading,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          prog_we,
    output logic [AW-1:0] prog_addr,
    output logic [15:0]   prog_data,
    output logic [1:0]    prog_mask,
    input  logic          prog_rdy,
    output logic          dwnld_busy,
    output logic          overflow
);

    // Entry layout: {word address, byte lane, byte}.
    localparam int EW = AW + 9;
    localparam logic [7:0] HOLD_V = 8'(HOLD);

    wr_state_t     state_q, state_d;
    logic          prog_we_q, prog_we_d;
    logic [AW-1:0] prog_addr_q, prog_addr_d;
    logic [15:0]   prog_data_q, prog_data_d;
    logic [1:0]    prog_mask_q, prog_mask_d;
    logic [7:0]    hold_q, hold_d;
    logic          busy_q, busy_d;
    logic          overflow_q, overflow_d;
    logic          dl_prev_q, dl_prev_d;

    logic          push_s;
    logic          pop_s;
    logic          dl_rise_s;
    logic          dl_fall_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic [EW-1:0] fifo_din_s;
    logic [EW-1:0] fifo_dout_s;
    logic          unused_addr_s;

    assign push_s     = ioctl_wr && downloading;
    assign pop_s      = (state_q == WRITE) && prog_rdy;
    assign dl_rise_s  = downloading && !dl_prev_q;
    assign dl_fall_s  = !downloading && dl_prev_q;
    assign fifo_din_s = {ioctl_addr[AW:1], ioctl_addr[0], ioctl_dout};
    // Address bits above the SDRAM word range are deliberately discarded.
    assign unused_addr_s = ^ioctl_addr[24:AW+1];

    jtframe_dwnld_fifo #(
        .DW    (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (fifo_din_s),
        .dout  (fifo_dout_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );

    // Write FSM and hold counter. The head entry stays in the FIFO until the
    // write is acknowledged, so the FIFO count includes the in-flight byte.
    always_comb begin
        state_d     = state_q;
        prog_we_d   = prog_we_q;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;
        prog_mask_d = prog_mask_q;
        hold_d      = hold_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    prog_addr_d = fifo_dout_s[EW-1:9];
                    prog_mask_d = lane_mask(fifo_dout_s[8]);
                    prog_data_d = {fifo_dout_s[7:0], fifo_dout_s[7:0]};
                    prog_we_d   = 1'b1;
                    state_d     = WRITE;
                end else if (!downloading && (hold_q != 8'd0)) begin
                    hold_d = hold_q - 8'd1;
                end else begin
                    hold_d = hold_q;
                end
            end
            WRITE: begin
                if (prog_rdy) begin
                    prog_we_d = 1'b0;
                    state_d   = IDLE;
                    hold_d    = HOLD_V;
                end else begin
                    prog_we_d = 1'b1;
                end
            end
            default: begin
                prog_we_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
        if (dl_fall_s) begin
            hold_d = HOLD_V;
        end else begin
            hold_d = hold_d;
        end
    end

    // Sticky overflow (cleared when a new download starts) and busy flag.
    always_comb begin
        dl_prev_d = downloading;
        if (dl_rise_s) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (push_s && fifo_full_s && !pop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_d;
        end
        busy_d = downloading || !fifo_empty_s || (state_q == WRITE) ||
                 (hold_q != 8'd0);
    end

    // Control and output registers; reset abandons any pending request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prog_we_q   <= 1'b0;
            prog_addr_q <= '0;
            prog_data_q <= 16'h0000;
            prog_mask_q <= MASK_NONE;
            hold_q      <= 8'd0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            dl_prev_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prog_we_q   <= prog_we_d;
            prog_addr_q <= prog_addr_d;
            prog_data_q <= prog_data_d;
            prog_mask_q <= prog_mask_d;
            hold_q      <= hold_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
            dl_prev_q   <= dl_prev_d;
        end
    end

    assign prog_we    = prog_we_q;
    assign prog_addr  = prog_addr_q;
    assign prog_data  = prog_data_q;
    assign prog_mask  = prog_mask_q;
    assign dwnld_busy = busy_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_jtframe_dwnld_wrsched.sv
// Self-checking bench for jtframe_dwnld_wrsched: a scoreboard queue holds the
// expected SDRAM writes (pushed when a byte is driven and accepted by the
// bench's FIFO-occupancy model) and a monitor pops/compares each new request.
module tb_jtframe_dwnld_wrsched;

    localparam int AW    = 22;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          downloading = 1'b0;
    logic          ioctl_wr = 1'b0;
    logic [24:0]   ioctl_addr = 25'd0;
    logic [7:0]    ioctl_dout = 8'd0;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [15:0]   prog_data;
    logic [1:0]    prog_mask;
    logic          prog_rdy = 1'b0;
    logic          dwnld_busy;
    logic          overflow;

    // Expected write: {addr, mask, data}
    logic [AW+17:0] sb_q[$];
    int  model_cnt = 0;
    logic exp_ovf = 1'b0;
    logic dl_prev_m = 1'b0;
    logic rdy_ok = 1'b0;
    int  errs = 0;
    int  checks = 0;
    int  writes_seen = 0;
    logic we_prev = 1'b0;

    jtframe_dwnld_wrsched #(.AW(AW), .FIFO_DEPTH(DEPTH), .HOLD(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_rdy    (prog_rdy),
        .dwnld_busy  (dwnld_busy),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Update the bench model for the coming edge, then advance one cycle.
    task automatic tick();
        logic push_m;
        logic pop_m;
        if (rst) begin
            sb_q.delete();
            model_cnt = 0;
            exp_ovf   = 1'b0;
            dl_prev_m = 1'b0;
        end else begin
            push_m = downloading && ioctl_wr;
            pop_m  = prog_rdy && rdy_ok;
            if (downloading && !dl_prev_m) exp_ovf = 1'b0;
            dl_prev_m = downloading;
            if (push_m) begin
                if (model_cnt < DEPTH || pop_m) begin
                    sb_q.push_back({ioctl_addr[AW:1],
                                    (ioctl_addr[0] ? 2'b01 : 2'b10),
                                    ioctl_dout, ioctl_dout});
                    model_cnt++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
            if (pop_m) model_cnt--;
        end
        @(posedge clk);
        #1;
        ioctl_wr = 1'b0;
        prog_rdy = 1'b0;
        rdy_ok   = 1'b0;
    endtask

    task automatic push_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
    endtask

    task automatic wait_we();
        int n = 0;
        while (!prog_we && n < 20) begin
            tick();
            n++;
        end
        if (!prog_we) check_eq("we_timeout", 32'd0, 32'd1);
    endtask

    // Acknowledge the pending write after dly cycles of prog_we high.
    task automatic ack_write(input int dly);
        wait_we();
        repeat (dly) tick();
        prog_rdy = 1'b1;
        rdy_ok   = 1'b1;
        tick();
        check_eq("we_drop", {31'd0, prog_we}, 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_we"},   {31'd0, prog_we},    32'd0);
        check_eq({tag, "_addr"}, {10'd0, prog_addr},  32'd0);
        check_eq({tag, "_data"}, {16'd0, prog_data},  32'd0);
        check_eq({tag, "_mask"}, {30'd0, prog_mask},  32'd3);
        check_eq({tag, "_busy"}, {31'd0, dwnld_busy}, 32'd0);
        check_eq({tag, "_ovf"},  {31'd0, overflow},   32'd0);
    endtask

    // Scoreboard monitor: every new request must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && prog_we && !we_prev) begin
            writes_seen++;
            if (sb_q.size() == 0) begin
                check_eq("spurious_we", 32'd1, 32'd0);
            end else begin
                logic [AW+17:0] e;
                e = sb_q.pop_front();
                check_eq("wr_addr", {10'd0, prog_addr}, {10'd0, e[AW+17:18]});
                check_eq("wr_mask", {30'd0, prog_mask}, {30'd0, e[17:16]});
                check_eq("wr_data", {16'd0, prog_data}, {16'd0, e[15:0]});
            end
        end
        we_prev <= prog_we;
    end

    initial begin
        int w0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_vals("rst");

        // Single byte: latency and field mapping
        downloading = 1'b1;
        tick();
        push_byte(25'h000003, 8'hA5);
        check_eq("lat_n", {31'd0, prog_we}, 32'd0);
        tick();
        check_eq("lat_n1", {31'd0, prog_we}, 32'd1);
        check_eq("single_addr", {10'd0, prog_addr}, 32'h1);
        check_eq("single_data", {16'd0, prog_data}, 32'hA5A5);
        check_eq("single_mask", {30'd0, prog_mask}, 32'd1);
        tick();
        tick();
        prog_rdy = 1'b1;
        rdy_ok   = 1'b1;
        tick();
        check_eq("single_we_low", {31'd0, prog_we}, 32'd0);

        // Burst of 4 with slow acknowledge
        w0 = writes_seen;
        for (int i = 0; i < 4; i++) push_byte(25'(i), 8'h10 + 8'(i));
        for (int i = 0; i < 4; i++) ack_write(5);
        check_eq("burst_writes", writes_seen - w0, 32'd4);
        check_eq("burst_ovf", {31'd0, overflow}, {31'd0, exp_ovf});
        check_eq("burst_sb", sb_q.size(), 32'd0);

        // Overflow: 6 bytes with no acknowledge, 2 dropped
        w0 = writes_seen;
        for (int i = 0; i < 6; i++) push_byte(25'h100 + 25'(i), 8'h40 + 8'(i));
        check_eq("ovf_set", {31'd0, overflow}, 32'd1);
        check_eq("ovf_model", {31'd0, overflow}, {31'd0, exp_ovf});
        for (int i = 0; i < 4; i++) ack_write(1);
        check_eq("ovf_writes", writes_seen - w0, 32'd4);
        check_eq("ovf_sticky", {31'd0, overflow}, 32'd1);
        downloading = 1'b0;
        tick();
        downloading = 1'b1;
        tick();
        check_eq("ovf_clear", {31'd0, overflow}, 32'd0);

        // Full FIFO with simultaneous push and pop
        w0 = writes_seen;
        for (int i = 0; i < 4; i++) push_byte(25'h200 + 25'(i), 8'h80 + 8'(i));
        wait_we();
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h000209;
        ioctl_dout = 8'h99;
        prog_rdy   = 1'b1;
        rdy_ok     = 1'b1;
        tick();
        check_eq("full_pop_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 4; i++) ack_write(2);
        check_eq("full_pop_writes", writes_seen - w0, 32'd5);
        check_eq("full_pop_sb", sb_q.size(), 32'd0);

        // Busy tail after last acknowledge
        push_byte(25'h000300, 8'h01);
        push_byte(25'h000301, 8'h02);
        downloading = 1'b0;
        tick();
        check_eq("tail_busy_fall", {31'd0, dwnld_busy}, 32'd1);
        ack_write(1);
        tick();
        check_eq("tail_we2", {31'd0, prog_we}, 32'd1);
        prog_rdy = 1'b1;
        rdy_ok   = 1'b1;
        tick();
        check_eq("tail_busy_L", {31'd0, dwnld_busy}, 32'd1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check_eq("tail_busy_hold", {31'd0, dwnld_busy}, 32'd1);
        end
        tick();
        check_eq("tail_busy_end", {31'd0, dwnld_busy}, 32'd0);

        // Reset in the middle of a write with entries queued
        downloading = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) push_byte(25'h400 + 25'(i), 8'hC0 + 8'(i));
        wait_we();
        check_eq("mid_we", {31'd0, prog_we}, 32'd1);
        rst = 1'b1;
        downloading = 1'b0;
        tick();
        rst = 1'b0;
        check_reset_vals("mid_rst");
        w0 = writes_seen;
        prog_rdy = 1'b1;
        tick();
        repeat (5) tick();
        check_eq("stale_rdy_we", {31'd0, prog_we}, 32'd0);
        check_eq("stale_rdy_writes", writes_seen - w0, 32'd0);
        check_eq("stale_rdy_busy", {31'd0, dwnld_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
